// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch sequencing controller.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie, the requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Shares a bank of SR latches between two requesters: drives one S/R pulse per command,
// waits a hold gap, reads Q back and tracks the expected latch states.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_LATCH   = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int IDX_W     = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [IDX_W-1:0]   req0_idx,
  input  logic               req0_op,
  input  logic [IDX_W-1:0]   req1_idx,
  input  logic               req1_op,
  output logic [N_LATCH-1:0] S,
  output logic [N_LATCH-1:0] R,
  input  logic [N_LATCH-1:0] Q_fb,
  output logic [N_LATCH-1:0] shadow_q,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  // One extra bit so the range limit is representable even when N_LATCH is a power of two.
  localparam logic [IDX_W:0]   IDX_LIM    = (IDX_W + 1)'(N_LATCH);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               op_reg, op_next;
  logic               last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N_LATCH-1:0] s_reg, s_next;
  logic [N_LATCH-1:0] r_reg, r_next;
  logic [N_LATCH-1:0] shadow_reg, shadow_next;
  logic               err_reg, err_next;

  logic [1:0]         gnt;
  logic               accept;
  logic [IDX_W-1:0]   idx_sel;
  logic               op_sel;
  logic               idx_bad;
  logic [N_LATCH-1:0] sel_hot;
  logic [N_LATCH-1:0] cur_hot;
  logic               fb_bit;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .enable     (state_reg == IDLE),
    .gnt        (gnt)
  );

  assign accept  = |gnt;
  assign idx_sel = gnt[1] ? req1_idx : req0_idx;
  assign op_sel  = gnt[1] ? req1_op  : req0_op;
  assign idx_bad = {1'b0, idx_sel} >= IDX_LIM;

  // One-hot decodes of the incoming and in-flight latch index.
  for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_dec
    assign sel_hot[gi] = (idx_sel == IDX_W'(gi));
    assign cur_hot[gi] = (idx_reg == IDX_W'(gi));
  end

  assign fb_bit = |(Q_fb & cur_hot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      op_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      s_reg          <= '0;
      r_reg          <= '0;
      shadow_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      op_reg         <= op_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      s_reg          <= s_next;
      r_reg          <= r_next;
      shadow_reg     <= shadow_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    op_next         = op_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    s_next          = '0;
    r_next          = '0;
    shadow_next     = shadow_reg;
    // A new error event below overrides a coincident clear.
    err_next        = err_reg & ~err_clr;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          last_grant_next = gnt[1];
          idx_next        = idx_sel;
          op_next         = op_sel;
          if (idx_bad) begin
            err_next = 1'b1;
          end else begin
            state_next = PULSE;
            cnt_next   = '0;
            s_next     = (op_sel == OP_SET)   ? sel_hot : '0;
            r_next     = (op_sel == OP_RESET) ? sel_hot : '0;
          end
        end
      end
      PULSE: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          s_next   = s_reg;
          r_next   = r_reg;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      CHECK: begin
        shadow_next = (op_reg == OP_SET) ? (shadow_reg | cur_hot) : (shadow_reg & ~cur_hot);
        if (fb_bit != op_reg) begin
          err_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = gnt;
    S         = s_reg;
    R         = r_reg;
    shadow_q  = shadow_reg;
    err       = err_reg;
    busy      = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl with a behavioural latch bank and a stuck-at-0 fault mask.
module tb_sr_latch_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req0_idx;
  logic       req0_op;
  logic [1:0] req1_idx;
  logic       req1_op;
  logic [3:0] S;
  logic [3:0] R;
  logic [3:0] Q_fb;
  logic [3:0] shadow_q;
  logic       busy;
  logic       err;
  logic       err_clr;

  // Second instance with a non-power-of-two bank to reach an out-of-range index.
  logic [1:0] b_req_valid;
  logic [1:0] b_req_ready;
  logic [1:0] b_req0_idx;
  logic       b_req0_op;
  logic [1:0] b_req1_idx;
  logic       b_req1_op;
  logic [2:0] b_S;
  logic [2:0] b_R;
  logic [2:0] b_Q_fb;
  logic [2:0] b_shadow_q;
  logic       b_busy;
  logic       b_err;
  logic       b_err_clr;

  logic [3:0] q_bank = '0;
  logic [3:0] stuck0 = '0;
  int n_checks = 0;
  int n_errors = 0;

  sr_latch_ctrl #(.N_LATCH(4), .PULSE_CYC(2), .GAP_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_idx(req0_idx), .req0_op(req0_op), .req1_idx(req1_idx), .req1_op(req1_op),
    .S(S), .R(R), .Q_fb(Q_fb), .shadow_q(shadow_q), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  sr_latch_ctrl #(.N_LATCH(3), .PULSE_CYC(2), .GAP_CYC(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req0_idx(b_req0_idx), .req0_op(b_req0_op), .req1_idx(b_req1_idx), .req1_op(b_req1_op),
    .S(b_S), .R(b_R), .Q_fb(b_Q_fb), .shadow_q(b_shadow_q), .busy(b_busy), .err(b_err),
    .err_clr(b_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (S[i])      q_bank[i] <= 1'b1;
      else if (R[i]) q_bank[i] <= 1'b0;
    end
  end

  assign Q_fb   = q_bank & ~stuck0;
  assign b_Q_fb = 3'b000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every-cycle safety properties on both instances.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("s_and_r", {28'd0, S & R}, 32'd0);
      check("sr_onehot", 32'($countones(S | R) <= 1), 32'd1);
      check("rdy_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("b_sr_idle", {29'd0, b_S | b_R}, 32'd0);
    end
  end

  // Issue one command and walk it through PULSE, GAP and CHECK with fixed-cycle expectations.
  task automatic run_cmd(input int r, input logic [1:0] idx, input logic op,
                         input logic [3:0] exp_s, input logic [3:0] exp_r,
                         input logic [3:0] exp_shadow, input logic exp_err,
                         input logic clr_in_check);
    logic [1:0] exp_rdy;
    exp_rdy = (r == 1) ? 2'b10 : 2'b01;
    if (r == 1) begin
      req1_idx = idx; req1_op = op;
    end else begin
      req0_idx = idx; req0_op = op;
    end
    req_valid = exp_rdy;
    #1;
    check("ready_accept", {30'd0, req_ready}, {30'd0, exp_rdy});
    check("s_before_pulse", {28'd0, S | R}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) check("ready_in_pulse", {30'd0, req_ready}, 32'd0);
      req_valid = 2'b00;
      check("s_pulse", {28'd0, S}, {28'd0, exp_s});
      check("r_pulse", {28'd0, R}, {28'd0, exp_r});
      check("busy_pulse", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("sr_gap", {28'd0, S | R}, 32'd0);
    check("busy_gap", {31'd0, busy}, 32'd1);
    @(negedge clk);
    err_clr = clr_in_check;
    #1;
    check("busy_check", {31'd0, busy}, 32'd1);
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("shadow", {28'd0, shadow_q}, {28'd0, exp_shadow});
    check("err", {31'd0, err}, {31'd0, exp_err});
    $display("txn req%0d idx=%0d op=%0d shadow_q=%b err=%b", r, idx, op, shadow_q, err);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst_n = 1'b0;
    req_valid = 2'b00; req0_idx = '0; req0_op = 1'b0; req1_idx = '0; req1_op = 1'b0;
    err_clr = 1'b0;
    b_req_valid = 2'b00; b_req0_idx = '0; b_req0_op = 1'b0; b_req1_idx = '0; b_req1_op = 1'b0;
    b_err_clr = 1'b0;
    #2;
    check("rst_s", {28'd0, S}, 32'd0);
    check("rst_r", {28'd0, R}, 32'd0);
    check("rst_shadow", {28'd0, shadow_q}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Set latch 2 from requester 0, then reset it from requester 1.
    run_cmd(0, 2'd2, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
    run_cmd(1, 2'd2, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);

    // Both requesters always valid: grants must alternate starting with requester 0.
    req0_idx = 2'd0; req0_op = 1'b1; req1_idx = 2'd1; req1_op = 1'b1;
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      g = 2'b00;
      for (int c = 0; c < 20 && g == 2'b00; c++) begin
        #1;
        g = req_ready;
        if (g == 2'b00) @(negedge clk);
      end
      check("rr_grant", {30'd0, g}, {30'd0, exp_g[n]});
      $display("txn rr slot=%0d grant=%b", n, g);
      @(negedge clk);
      #1;
      check("rr_ready_pulse", {30'd0, req_ready}, 32'd0);
    end
    req_valid = 2'b00;
    repeat (6) @(negedge clk);
    #1;
    check("rr_shadow", {28'd0, shadow_q}, 32'h3);
    check("rr_err", {31'd0, err}, 32'd0);

    // Latch 1 feedback stuck at 0: readback mismatch sets err, which is sticky.
    stuck0 = 4'b0010;
    run_cmd(0, 2'd1, 1'b1, 4'b0010, 4'b0000, 4'b0011, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("err_cleared", {31'd0, err}, 32'd0);
    $display("txn err_clr err=%b", err);
    // Clear coinciding with a fresh mismatch: the error wins.
    run_cmd(1, 2'd1, 1'b1, 4'b0010, 4'b0000, 4'b0011, 1'b1, 1'b1);

    // Out-of-range index on the 3-latch instance.
    b_req0_idx = 2'd3; b_req0_op = 1'b1; b_req_valid = 2'b01;
    #1;
    check("b_ready", {30'd0, b_req_ready}, 32'd1);
    check("b_err_pre", {31'd0, b_err}, 32'd0);
    @(negedge clk);
    b_req_valid = 2'b00;
    #1;
    check("b_err", {31'd0, b_err}, 32'd1);
    check("b_busy", {31'd0, b_busy}, 32'd0);
    check("b_sr", {29'd0, b_S | b_R}, 32'd0);
    @(negedge clk);
    #1;
    check("b_busy_later", {31'd0, b_busy}, 32'd0);
    $display("txn b_req0 idx=3 err=%b busy=%b", b_err, b_busy);

    // Reset mid-PULSE: outputs drop before the next clock edge; tie afterwards goes to requester 0.
    req0_idx = 2'd3; req0_op = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    #1;
    check("mid_pulse_s", {28'd0, S}, 32'h8);
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s", {28'd0, S}, 32'd0);
    check("arst_r", {28'd0, R}, 32'd0);
    check("arst_shadow", {28'd0, shadow_q}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_idx = 2'd0; req0_op = 1'b1; req1_idx = 2'd1; req1_op = 1'b0;
    req_valid = 2'b11;
    #1;
    check("tie_after_reset", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (6) @(negedge clk);
    #1;
    check("post_reset_shadow", {28'd0, shadow_q}, 32'h1);
    check("post_reset_err", {31'd0, err}, 32'd0);
    $display("txn post_reset req0 idx=0 op=1 shadow_q=%b err=%b", shadow_q, err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
Name: sr_latch_ctrl

Overview:
Sequencing controller that shares a bank of N_LATCH sr_latch instances between two command requesters. It arbitrates round-robin and drives each latch's S/R inputs with fixed-width pulses followed by a hold gap. By construction S=R=1 is never driven. After each command it reads back Q, keeps a shadow copy of the expected latch states and flags mismatches. It sits between control logic and the latch bank, and is the only driver of the latch S/R pins.

Parameters:
N_LATCH, 4, number of sr_latch instances driven
PULSE_CYC, 2, cycles S or R is held high per command (>=1)
GAP_CYC, 1, cycles S=R=0 (hold state) after each pulse, before readback (>=1)
IDX_W, $clog2(N_LATCH) (min 1), width of latch index fields

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester command valid
req_ready  out  2  per-requester accept; transfer when valid&ready
req0_idx  in  IDX_W  requester 0 target latch
req0_op  in  1  requester 0 op: 1=set, 0=reset
req1_idx  in  IDX_W  requester 1 target latch
req1_op  in  1  requester 1 op
S  out  N_LATCH  set inputs to latch bank
R  out  N_LATCH  reset inputs to latch bank
Q_fb  in  N_LATCH  Q outputs fed back from latch bank
shadow_q  out  N_LATCH  expected latch states
busy  out  1  high whenever state != IDLE
err  out  1  sticky error: readback mismatch or out-of-range idx
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, rst_n=0): S=0, R=0, shadow_q=0, err=0, busy=0, state=IDLE, last_grant=1 (requester 0 wins the first tie), counters=0. Latch contents are not touched; shadow_q=0 does not reflect them until commands are issued.
- States: IDLE -> PULSE -> GAP -> CHECK -> IDLE.
- IDLE: req_ready is combinational, at most one bit high. It goes high for the granted requester only when that requester's valid is high.
  - Both valid: grant the requester not equal to last_grant.
  - On transfer: latch idx/op, update last_grant, go to PULSE.
  - If idx >= N_LATCH: set err, stay in IDLE, drive no pulse.
- PULSE: S[idx]=op, R[idx]=!op, all other S/R bits 0. S/R are registered: first high cycle is the cycle after acceptance. Lasts exactly PULSE_CYC cycles.
- GAP: all S/R=0 for GAP_CYC cycles.
- CHECK (1 cycle): sample Q_fb[idx]. shadow_q[idx] <= op. If Q_fb[idx] != op, err <= 1. Return to IDLE.
- Latency: accept cycle t; S/R high t+1..t+PULSE_CYC; CHECK at t+PULSE_CYC+GAP_CYC+1. Earliest next accept is the following cycle, giving a throughput of PULSE_CYC+GAP_CYC+2 cycles per command.
- Invariant: (S & R) == 0 every cycle, and at most one S/R bit is high at a time.
- req_ready=0 in all non-IDLE states. Requesters hold valid/idx/op stable until accepted.
- err_clr clears err. If err_clr coincides with a new error event, the error wins and err stays 1.
- Reset mid-PULSE: S/R drop to 0 immediately (asynchronously); the in-flight command is lost and no readback occurs.
- Q_fb is sampled only in CHECK; it is ignored in all other states.

Decomposition:
- Package sr_ctrl_pkg:
  - state enum {IDLE, PULSE, GAP, CHECK}
  - constants OP_SET=1'b1, OP_RESET=1'b0
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, enable.
  - Output: one-hot gnt[1:0].
  - Instantiated once in the controller.
- The latch bank (N_LATCH sr_latch instances) is instantiated in the testbench, not inside this block.

Test Plan:
- Set latch 2 via req0 (op=1), PULSE_CYC=2, GAP_CYC=1 -> S=4'b0100 for exactly 2 cycles, R=0 throughout, CHECK at t+4, shadow_q=4'b0100, err=0.
- Reset latch 2 via req1 after it has been set -> R=4'b0100 for 2 cycles, then Q_fb[2]=0, shadow_q=4'b0000, err=0.
- Both requesters valid in every slot, 4 commands -> grants alternate 0,1,0,1; each req_ready bit is a single-cycle pulse; S&R==0 checked every cycle.
- Bench forces Q_fb[1] stuck at 0, then set latch 1 -> err=1 after CHECK and stays high; err_clr pulse -> err=0; err_clr in the same cycle as a new mismatch -> err stays 1.
- N_LATCH=3, command idx=3 -> accepted, no S/R activity, err=1, busy stays 0.
- rst_n asserted mid-PULSE -> S=R=0 in the same cycle (before the next clock edge), shadow_q=0, err=0; the next command after release is granted to requester 0 on a tie.
